// File: rtl/aes_decipher_scheduler_if.sv
// ---------------------------------------------------------------------------
// aes_decipher_scheduler_if
// Bundles the control handshake between the AES inverse-cipher round
// scheduler and its surroundings (block source, datapath, plaintext consumer).
//   key_ready   : expanded key schedule is valid (gates acceptance only)
//   in_valid    : ciphertext block offered        in_ready  : block accepted
//   enable      : round advance permitted         abort     : flush to IDLE
//   load_state  : datapath captures initial AddRoundKey result
//   do_round    : datapath performs one inverse round
//   do_final    : datapath performs the final inverse round
//   round_idx   : round-key index into the expanded keys
//   out_valid   : plaintext valid                 out_ready : consumer takes it
//   busy        : scheduler not idle              blocks_done : completed blocks
// Modports: slave = scheduler side, master = environment side.
// ---------------------------------------------------------------------------
interface aes_decipher_scheduler_if;
    logic        key_ready;
    logic        in_valid;
    logic        in_ready;
    logic        enable;
    logic        abort;
    logic        load_state;
    logic        do_round;
    logic        do_final;
    logic [3:0]  round_idx;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [15:0] blocks_done;

    modport slave (
        input  key_ready, in_valid, enable, abort, out_ready,
        output in_ready, load_state, do_round, do_final, round_idx,
               out_valid, busy, blocks_done
    );

    modport master (
        output key_ready, in_valid, enable, abort, out_ready,
        input  in_ready, load_state, do_round, do_final, round_idx,
               out_valid, busy, blocks_done
    );
endinterface

// File: rtl/aes_decipher_scheduler.sv
// ---------------------------------------------------------------------------
// aes_decipher_scheduler
// Sequences an iterative AES inverse cipher: on acceptance of a ciphertext
// block it requests the initial AddRoundKey with key NR, then NR-1 inverse
// rounds with keys NR-1 down to 1, then the final inverse round with key 0,
// and finally presents the plaintext until the consumer takes it.
// Parameters:
//   NR : number of AES rounds (10/12/14)
//   NK : key length in 32-bit words, informational only
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : control bundle (slave modport), see aes_decipher_scheduler_if
// ---------------------------------------------------------------------------
module aes_decipher_scheduler #(
    parameter int NR = 10,
    parameter int NK = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    aes_decipher_scheduler_if.slave  bus
);

    // NK has no bearing on the schedule; it is folded in here only so the
    // parameter is referenced.
    localparam int         NR_EFF = (NK > 0) ? NR : NR;
    localparam logic [3:0] NR_IDX = 4'(NR_EFF);
    localparam logic [3:0] NR_M1  = 4'(NR_EFF - 1);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [15:0] blocks_q;
    logic [15:0] blocks_next;
    logic        accept;

    // Acceptance is only possible while idle with a valid key schedule and
    // no flush pending; held low during reset so every output is quiet.
    assign bus.in_ready = reset && (state == IDLE) && bus.key_ready && !bus.abort;
    assign accept       = bus.in_ready && bus.in_valid;

    assign bus.busy        = (state != IDLE);
    assign bus.blocks_done = blocks_q;

    // State, round counter and completed-block counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            blocks_q <= 16'd0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            blocks_q <= blocks_next;
        end
    end

    // Next-state and datapath strobes. The counter holds the key index of
    // the inverse round about to run; reaching 1 means the last full round.
    // Abort overrides everything: it forces IDLE, clears the counter, never
    // counts a block and suppresses the datapath strobes of that cycle.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        blocks_next    = blocks_q;
        bus.load_state = 1'b0;
        bus.do_round   = 1'b0;
        bus.do_final   = 1'b0;
        bus.round_idx  = 4'd0;
        bus.out_valid  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    bus.load_state = 1'b1;
                    bus.round_idx  = NR_IDX;
                    cnt_next       = NR_M1;
                    state_next     = (NR_EFF == 1) ? FINAL : ROUND;
                end
            end
            ROUND: begin
                bus.round_idx = cnt;
                bus.do_round  = bus.enable && !bus.abort;
                if (bus.enable) begin
                    cnt_next = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_next = FINAL;
                    end
                end
            end
            FINAL: begin
                bus.round_idx = 4'd0;
                bus.do_final  = bus.enable && !bus.abort;
                if (bus.enable) begin
                    state_next = DONE;
                    if (blocks_q != 16'hFFFF) begin
                        blocks_next = blocks_q + 16'd1;
                    end
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (bus.abort) begin
            state_next  = IDLE;
            cnt_next    = 4'd0;
            blocks_next = blocks_q;
        end
    end

endmodule

// File: tb/tb_aes_decipher_scheduler.sv
// ---------------------------------------------------------------------------
// tb_aes_decipher_scheduler
// Drives an NR=10 and an NR=14 scheduler from the same inputs and compares
// every output, every cycle, against a transaction-level model that only
// tracks "block in flight" and "how many key steps have been applied".
// Directed scenarios cover the documented timing cases, then a random phase
// exercises arbitrary interleavings of enable, abort, key_ready and
// out_ready.
// ---------------------------------------------------------------------------
module tb_aes_decipher_scheduler;

    logic clk = 1'b0;
    logic reset;
    logic key_ready, in_valid, enable, abort, out_ready;

    always #5 clk = ~clk;

    aes_decipher_scheduler_if bus10 ();
    aes_decipher_scheduler_if bus14 ();

    assign bus10.key_ready = key_ready;
    assign bus10.in_valid  = in_valid;
    assign bus10.enable    = enable;
    assign bus10.abort     = abort;
    assign bus10.out_ready = out_ready;
    assign bus14.key_ready = key_ready;
    assign bus14.in_valid  = in_valid;
    assign bus14.enable    = enable;
    assign bus14.abort     = abort;
    assign bus14.out_ready = out_ready;

    aes_decipher_scheduler #(.NR(10), .NK(4)) dut10 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus10)
    );

    aes_decipher_scheduler #(.NR(14), .NK(8)) dut14 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus14)
    );

    typedef struct packed {
        logic        in_ready;
        logic        load_state;
        logic        do_round;
        logic        do_final;
        logic [3:0]  round_idx;
        logic        out_valid;
        logic        busy;
        logic [15:0] blocks_done;
    } obs_t;

    int total = 0;
    int bad   = 0;

    // Reference model: a block is either absent or in flight; "steps" counts
    // key operations applied after the initial AddRoundKey (0..NR). Once all
    // NR are done the plaintext is waiting for the consumer.
    int mNr[2] = '{10, 14};
    bit mActive[2];
    int mSteps[2];
    int mDone[2];

    int cyc = 0;
    int acc10 = 0;
    int ovLat10 = -1;
    bit ovSeen10 = 1'b1;
    int ovCount10 = 0;
    int acc14q[$];

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 2; i++) begin
            mActive[i] = 1'b0;
            mSteps[i]  = 0;
            mDone[i]   = 0;
        end
    endtask

    // Outputs implied by the model state and the current inputs.
    task automatic expectOutputs(input int i, output obs_t e);
        e = '0;
        e.blocks_done = 16'(mDone[i]);
        if (!reset) begin
            e = '0;
        end else if (!mActive[i]) begin
            e.in_ready   = key_ready && !abort;
            e.load_state = e.in_ready && in_valid;
            if (e.load_state) e.round_idx = 4'(mNr[i]);
        end else begin
            e.busy = 1'b1;
            if (mSteps[i] < mNr[i] - 1) begin
                e.round_idx = 4'(mNr[i] - 1 - mSteps[i]);
                e.do_round  = enable && !abort;
            end else if (mSteps[i] == mNr[i] - 1) begin
                e.round_idx = 4'd0;
                e.do_final  = enable && !abort;
            end else begin
                e.out_valid = 1'b1;
            end
        end
    endtask

    task automatic checkAll();
        for (int i = 0; i < 2; i++) begin
            obs_t o;
            obs_t e;
            string n;
            n = (i == 0) ? "nr10" : "nr14";
            if (i == 0)
                o = {bus10.in_ready, bus10.load_state, bus10.do_round, bus10.do_final,
                     bus10.round_idx, bus10.out_valid, bus10.busy, bus10.blocks_done};
            else
                o = {bus14.in_ready, bus14.load_state, bus14.do_round, bus14.do_final,
                     bus14.round_idx, bus14.out_valid, bus14.busy, bus14.blocks_done};
            expectOutputs(i, e);
            checkOutput({n, ".in_ready"},    32'(o.in_ready),    32'(e.in_ready));
            checkOutput({n, ".load_state"},  32'(o.load_state),  32'(e.load_state));
            checkOutput({n, ".do_round"},    32'(o.do_round),    32'(e.do_round));
            checkOutput({n, ".do_final"},    32'(o.do_final),    32'(e.do_final));
            checkOutput({n, ".round_idx"},   32'(o.round_idx),   32'(e.round_idx));
            checkOutput({n, ".out_valid"},   32'(o.out_valid),   32'(e.out_valid));
            checkOutput({n, ".busy"},        32'(o.busy),        32'(e.busy));
            checkOutput({n, ".blocks_done"}, 32'(o.blocks_done), 32'(e.blocks_done));
        end
    endtask

    task automatic advanceModel();
        for (int i = 0; i < 2; i++) begin
            if (abort) begin
                mActive[i] = 1'b0;
            end else if (!mActive[i]) begin
                if (key_ready && in_valid) begin
                    mActive[i] = 1'b1;
                    mSteps[i]  = 0;
                end
            end else if (mSteps[i] < mNr[i]) begin
                if (enable) begin
                    mSteps[i]++;
                    if (mSteps[i] == mNr[i] && mDone[i] < 65535) mDone[i]++;
                end
            end else if (out_ready) begin
                mActive[i] = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive inputs just after the falling edge, check the
    // outputs, note timing events, step the model, wait for the next fall.
    task automatic applyStimulus(input bit kr, input bit iv, input bit en,
                                 input bit ab, input bit ordy);
        key_ready = kr;
        in_valid  = iv;
        enable    = en;
        abort     = ab;
        out_ready = ordy;
        #1;
        checkAll();
        if (bus10.load_state) begin
            acc10    = cyc;
            ovSeen10 = 1'b0;
        end
        if (bus10.out_valid) begin
            ovCount10++;
            if (!ovSeen10) begin
                ovLat10  = cyc - acc10;
                ovSeen10 = 1'b1;
            end
        end
        if (bus14.load_state) acc14q.push_back(cyc);
        if (reset) advanceModel();
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) applyStimulus(1, 0, 1, 0, 1);
        ovLat10   = -1;
        ovCount10 = 0;
    endtask

    initial begin
        int bdBefore;
        reset     = 1'b0;
        key_ready = 1'b0;
        in_valid  = 1'b0;
        enable    = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        resetModel();
        #1;
        checkAll();
        @(negedge clk);
        key_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        checkAll();
        @(negedge clk);
        reset = 1'b1;

        // Reset in the middle of a block discards it without a count.
        applyStimulus(1, 1, 1, 0, 1);
        for (int k = 0; k < 4; k++) applyStimulus(1, 0, 1, 0, 1);
        #2;
        reset = 1'b0;
        resetModel();
        #1;
        checkAll();
        checkOutput("midblock_reset.blocks_done", 32'(bus10.blocks_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drain();

        // Single block, enable held: out_valid 11 cycles after accept.
        applyStimulus(1, 1, 1, 0, 1);
        for (int k = 0; k < 14; k++) applyStimulus(1, 0, 1, 0, 1);
        checkOutput("single.latency", 32'(ovLat10), 32'd11);
        checkOutput("single.blocks_done", 32'(bus10.blocks_done), 32'd1);
        drain();

        // Three stalled cycles while the counter sits at 5.
        applyStimulus(1, 1, 1, 0, 1);
        for (int k = 1; k <= 4; k++) applyStimulus(1, 0, 1, 0, 1);
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, 1);
        for (int k = 0; k < 10; k++) applyStimulus(1, 0, 1, 0, 1);
        checkOutput("stall.latency", 32'(ovLat10), 32'd14);
        drain();

        // Consumer back-pressure: out_valid held through four refused cycles.
        applyStimulus(1, 1, 1, 0, 0);
        for (int k = 1; k <= 14; k++) applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(1, 1, 1, 0, 1);
        applyStimulus(1, 0, 1, 0, 1);
        checkOutput("backpressure.ov_cycles", 32'(ovCount10), 32'd5);
        drain();

        // Abort part-way through, then a fresh block runs to completion.
        bdBefore = int'(bus10.blocks_done);
        applyStimulus(1, 1, 1, 0, 1);
        for (int k = 1; k < 6; k++) applyStimulus(1, 0, 1, 0, 1);
        applyStimulus(1, 0, 1, 1, 1);
        for (int k = 0; k < 6; k++) applyStimulus(1, 0, 1, 0, 1);
        checkOutput("abort.blocks_done", 32'(bus10.blocks_done), 32'(bdBefore));
        drain();
        applyStimulus(1, 1, 1, 0, 1);
        for (int k = 0; k < 13; k++) applyStimulus(1, 0, 1, 0, 1);
        checkOutput("abort.reaccept_blocks", 32'(bus10.blocks_done), 32'(bdBefore + 1));
        drain();

        // key_ready low blocks acceptance until it rises.
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 0, 1);
        applyStimulus(1, 1, 1, 0, 1);
        applyStimulus(1, 0, 1, 0, 1);
        checkOutput("keyready.accept_cycle", 32'(acc10), 32'(cyc - 2));
        drain();

        // Back-to-back blocks on the NR=14 instance.
        acc14q.delete();
        for (int k = 0; k < 50; k++) applyStimulus(1, 1, 1, 0, 1);
        if (acc14q.size() >= 3) begin
            checkOutput("b2b.gap1", 32'(acc14q[1] - acc14q[0]), 32'd16);
            checkOutput("b2b.gap2", 32'(acc14q[2] - acc14q[1]), 32'd16);
        end else begin
            checkOutput("b2b.accepts", 32'(acc14q.size()), 32'd3);
        end
        drain();

        // Random interleavings against the model.
        for (int k = 0; k < 600; k++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                          $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_decipher_scheduler.md
AES_DECIPHER_SCHEDULER -- requirements
Module: aes_decipher_scheduler

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of AES rounds (10/12/14).
REQ-002 SHALL have parameter NK, default 4, meaning the key length in 32-bit words; NK is informational only and the logic does not depend on it.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port key_ready, input, 1 bit: the expanded key schedule is valid.
REQ-006 SHALL have port in_valid, input, 1 bit: a ciphertext block is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the scheduler accepts a block this cycle.
REQ-008 SHALL have port enable, input, 1 bit: round advance permitted; low freezes ROUND/FINAL.
REQ-009 SHALL have port abort, input, 1 bit: synchronous flush to IDLE.
REQ-010 SHALL have port load_state, output, 1 bit: datapath captures input AddRoundKey result.
REQ-011 SHALL have port do_round, output, 1 bit: datapath performs one inverse round.
REQ-012 SHALL have port do_final, output, 1 bit: datapath performs the final inverse round.
REQ-013 SHALL have port round_idx, output, 4 bits: the round-key index to select from the expanded keys.
REQ-014 SHALL have port out_valid, output, 1 bit: the plaintext in the datapath state is valid.
REQ-015 SHALL have port out_ready, input, 1 bit: the consumer takes the plaintext.
REQ-016 SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-017 SHALL have port blocks_done, output, 16 bits: the count of completed blocks.

Function
REQ-018 SHALL implement FSM states IDLE, ROUND, FINAL, DONE plus a registered round counter cnt (4 bits).
REQ-019 SHALL drive in_ready = (state==IDLE) & key_ready & ~abort, combinationally.
REQ-020 SHALL, in IDLE with in_valid&in_ready (accept cycle 0): load_state=1 and round_idx=NR that cycle; cnt<=NR-1; next state ROUND.
REQ-021 SHALL, for NR==1 (degenerate case), go directly from accept to FINAL.
REQ-022 SHALL, in ROUND: round_idx=cnt and do_round=enable; on enable, cnt<=cnt-1; on enable with cnt==1, go to FINAL.
REQ-023 SHALL, in FINAL: round_idx=0 and do_final=enable; on enable, go to DONE and increment blocks_done (saturating at 16'hFFFF).
REQ-024 SHALL, in DONE: out_valid=1, held stable until out_ready=1, then go to IDLE; there is no new accept in the same cycle.
REQ-025 SHALL keep load_state, do_round and do_final mutually exclusive and low outside their own states; round_idx=0 in IDLE and DONE.
REQ-026 SHALL meet the following latency with enable held high: out_valid first high in cycle NR+1 after accept; the next accept is possible no earlier than cycle NR+2.
REQ-027 SHALL, when enable is low in ROUND/FINAL: hold state and cnt, keep do_round/do_final low and round_idx unchanged.
REQ-028 SHALL, on abort=1 in any state: next state IDLE, cnt<=0, no blocks_done increment, out_valid dropped next cycle; abort has priority over enable and out_ready.
REQ-029 SHALL make key_ready gate only acceptance; deassertion mid-block does not stall or abort.
REQ-030 SHALL, on in_valid while not in IDLE: not accept; the source holds its data.

Reset
REQ-031 SHALL, on reset low (asynchronous): state=IDLE, cnt=0, blocks_done=0; all outputs low (in_ready follows REQ-019 after release).
REQ-032 SHALL, on reset asserted mid-block: discard the block, assert no out_valid, and leave blocks_done at 0.

Verification
REQ-033 SHALL test this scenario: NR=10, key_ready=1, enable=1, single block accept -> load_state with idx 10 in cycle 0; do_round with idx 9..1 in cycles 1-9; do_final with idx 0 in cycle 10; out_valid in cycle 11; blocks_done=1.
REQ-034 SHALL test this scenario: enable low for 3 cycles while cnt==5 -> idx stays 5, do_round low; out_valid delayed to cycle 14.
REQ-035 SHALL test this scenario: out_ready low for 4 cycles in DONE -> out_valid held, in_ready=0; IDLE the cycle after out_ready=1.
REQ-036 SHALL test this scenario: abort in cycle 6 -> IDLE next cycle, no do_final, blocks_done unchanged, new block accepted afterwards.
REQ-037 SHALL test this scenario: key_ready=0 with in_valid=1 -> in_ready=0, no load_state; accept the cycle after key_ready rises.
REQ-038 SHALL test this scenario: NR=14, back-to-back blocks with out_ready=1 -> accepts spaced 16 cycles, round_idx sequence 14,13..1,0 each block.
